fir_block_accumulator: RTL
==========================

# fir_block_accumulator

Downstream consumer of the FIR datapath's registered `final_sum`. It sums fixed-length blocks of BLOCK_LEN valid filter outputs, tracks the per-block peak, and presents each block result on a valid/ready output port. It absorbs one completed block of backpressure and flags any samples dropped while stalled.

## Interface
- WIDTH, 4: FIR operand width; input sample width is SW = 2*WIDTH+2.
- BLOCK_LEN, 8: samples per block, ≥2; AW = SW + $clog2(BLOCK_LEN).
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- sum_in  in  SW  FIR `final_sum`, unsigned.
- sum_valid  in  1  sum_in is a valid sample this cycle.
- start  in  1  single-cycle pulse; begins accumulation.
- abort  in  1  discard partial block, return to IDLE.
- out_sum  out  AW  block sum.
- out_max  out  SW  largest sample in block.
- out_valid  out  1  out_sum/out_max hold an unconsumed result.
- out_ready  in  1  consumer accepts result.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: at least one valid sample dropped.

## Operation
- State: IDLE, ACCUM, HOLD. Internal: acc (AW), peak (SW), cnt (0..BLOCK_LEN-1).
- Priority each cycle: reset > abort > start > normal.
- abort (any state): next state IDLE, acc/peak/cnt cleared. The output register and overrun are untouched.
- IDLE: samples ignored. start → ACCUM, with acc/peak/cnt/overrun cleared.
- start in ACCUM/HOLD: restart, i.e. clear acc/peak/cnt/overrun and go to ACCUM.
- ACCUM, sum_valid=1, cnt<BLOCK_LEN-1: acc+=sum_in, peak=max(peak,sum_in), cnt++.
- ACCUM, sum_valid=1, cnt==BLOCK_LEN-1 (block completes), with final = acc+sum_in and final max:
  - If output register is free (out_valid=0, or out_valid&out_ready this cycle): load out_sum/out_max, out_valid=1, clear acc/peak/cnt, stay ACCUM.
  - Else: acc/peak keep the final values, go to HOLD.
- HOLD: every sum_valid=1 sample is dropped and sets overrun. When out_ready=1, the held result loads into the output register (out_valid stays 1), acc/peak/cnt clear, and the state goes to ACCUM. A sample arriving on that same cycle is also dropped.
- Output port: out_valid falls after an out_ready handshake unless a new result loads on the same edge. out_sum/out_max stay stable while out_valid=1 and out_ready=0.
- Arithmetic: unsigned, with no overflow possible. The maximum is BLOCK_LEN·(2^SW−1) < 2^AW. Ties in peak keep the value unchanged.

## Timing
- Reset values: out_sum=0, out_max=0, out_valid=0, overrun=0, busy=0; state IDLE, acc/peak/cnt=0.
- start sampled at edge E: busy=1 after E. The first sample captured is at edge E+1 or later.
- Latency: out_valid rises on the edge that captures the last sample of a block (visible the cycle after).
- Back-to-back blocks with out_ready held at 1: one result every BLOCK_LEN valid samples, with no bubbles.
- Gaps in sum_valid do not advance cnt.
- Handshake: the result transfers on a rising edge where out_valid=1 and out_ready=1. out_ready is ignored when out_valid=0.
- rst_n asserted mid-block clears everything immediately. No result is emitted for the partial block.
- The upstream filter output is registered. sum_valid must be aligned with the cycle in which `final_sum` reflects a fully primed delay line, which is driven by the feeding stage.

## Test plan
- Reset: WIDTH=4, BLOCK_LEN=4. Assert rst_n=0 after 2 samples of a block → all outputs 0, busy=0 immediately, no out_valid after release until a new start.
- Basic block: start, then samples 10,20,30,40 on consecutive cycles with out_ready=1 → out_valid=1 after the 4th capture edge, out_sum=100, out_max=40. A second block 1,2,3,4 → out_sum=10, out_max=4 with no idle cycle.
- Full scale: four samples of 900 (15·15·4) → out_sum=3600 in 12 bits, out_max=900, no wrap.
- Sparse input: samples 5,7,9,11 with sum_valid low on alternate cycles, and junk 1023 on sum_in while sum_valid=0 → out_sum=32, out_max=11.
- Backpressure: out_ready=0, blocks {10,20,30,40} then {1,1,1,1}, then 2 more valid samples → out_sum stays 100, state HOLD, overrun=1. Raise out_ready for 1 cycle → out_sum=4, out_max=1, out_valid stays 1, overrun stays 1. The next start clears overrun.
- Control precedence: abort after 2 samples in ACCUM → busy=0, out_valid unchanged. start+abort on the same cycle in IDLE → stays IDLE. start mid-block → next block sum counts only post-start samples.

Source files
------------

// File: rtl/fir_block_accumulator.sv
// fir_block_accumulator
//   Sums fixed-length blocks of BLOCK_LEN valid FIR outputs and tracks the
//   per-block peak. Each block result is presented on a valid/ready port.
//   One completed block can be held while the output is stalled. Samples
//   that arrive while a block is held are dropped and set a sticky flag.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   sum_in     : FIR final_sum sample (unsigned, SW bits)
//   sum_valid  : sum_in carries a valid sample this cycle
//   start      : begin (or restart) accumulation; clears overrun
//   abort      : discard the partial block and return to IDLE
//   out_sum    : block sum (AW bits)
//   out_max    : largest sample in the block
//   out_valid  : out_sum/out_max hold an unconsumed result
//   out_ready  : consumer accepts the result
//   busy       : state is not IDLE
//   overrun    : sticky, at least one valid sample was dropped
module fir_block_accumulator #(
  parameter int WIDTH     = 4,
  parameter int BLOCK_LEN = 8,
  parameter int SW        = 2*WIDTH+2,
  parameter int AW        = SW + $clog2(BLOCK_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] sum_in,
  input  logic          sum_valid,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] out_sum,
  output logic [SW-1:0] out_max,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          overrun
);
  localparam int CW = $clog2(BLOCK_LEN);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   peak_q, peak_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   osum_q, osum_d;
  logic [SW-1:0]   omax_q, omax_d;
  logic            ovld_q, ovld_d;
  logic            ovr_q, ovr_d;

  logic [AW-1:0]   acc_nx;
  logic [SW-1:0]   peak_nx;
  logic            out_free;
  logic            last;

  assign acc_nx   = acc_q + AW'(sum_in);
  // Strict compare: a tie leaves the peak unchanged.
  assign peak_nx  = (sum_in > peak_q) ? sum_in : peak_q;
  // The output register can take a new result if empty or being drained now.
  assign out_free = !ovld_q || out_ready;
  assign last     = (cnt_q == CW'(BLOCK_LEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      peak_q  <= '0;
      cnt_q   <= '0;
      osum_q  <= '0;
      omax_q  <= '0;
      ovld_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      osum_q  <= osum_d;
      omax_q  <= omax_d;
      ovld_q  <= ovld_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    osum_d  = osum_q;
    omax_d  = omax_q;
    ovr_d   = ovr_q;
    // Handshake drains the output; a load below may refill it on the same edge.
    ovld_d  = ovld_q && !out_ready;

    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      peak_d  = '0;
      cnt_d   = '0;
    end else if (start) begin
      state_d = ACCUM;
      acc_d   = '0;
      peak_d  = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (sum_valid) begin
            if (!last) begin
              acc_d  = acc_nx;
              peak_d = peak_nx;
              cnt_d  = cnt_q + CW'(1);
            end else if (out_free) begin
              osum_d = acc_nx;
              omax_d = peak_nx;
              ovld_d = 1'b1;
              acc_d  = '0;
              peak_d = '0;
              cnt_d  = '0;
            end else begin
              // Park the finished block until the consumer frees the port.
              acc_d   = acc_nx;
              peak_d  = peak_nx;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          // Nothing is captured while holding, including on the release cycle.
          if (sum_valid) ovr_d = 1'b1;
          if (out_ready) begin
            osum_d  = acc_q;
            omax_d  = peak_q;
            ovld_d  = 1'b1;
            acc_d   = '0;
            peak_d  = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = osum_q;
  assign out_max   = omax_q;
  assign out_valid = ovld_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule
